// File: rtl/uart_pkg.sv
// Shared constants for the UART channel register front-end:
// order codes, ISR bit positions and reset values.
package uart_pkg;

  localparam logic [3:0] ORD_RB  = 4'd1;
  localparam logic [3:0] ORD_IER = 4'd2;
  localparam logic [3:0] ORD_CTR = 4'd3;
  localparam logic [3:0] ORD_STR = 4'd4;
  localparam logic [3:0] ORD_DL  = 4'd5;
  localparam logic [3:0] ORD_DBG = 4'd6;
  localparam logic [3:0] ORD_TB  = 4'd7;
  localparam logic [3:0] ORD_THR = 4'd8;
  localparam logic [3:0] ORD_ISR = 4'd9;

  localparam int ISR_RXT = 0;
  localparam int ISR_TXE = 1;
  localparam int ISR_ROV = 2;
  localparam int ISR_PER = 3;
  localparam int ISR_W   = 4;

  localparam int CTR_DLAB_BIT = 5;

  localparam logic [ISR_W-1:0] IER_RESET = '0;
  localparam int               THR_RESET = 1;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt controller: edge-detected sticky status bits with W1C,
// a level rx-threshold bit, and a masked, registered irq.
module uart_irq_ctrl
  import uart_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tf_empty,
  input  logic                      rf_overrun,
  input  logic                      rf_pari_err,
  input  logic [CNT_W-1:0]          rf_number,
  input  logic [CNT_W-1:0]          thr,
  input  logic [ISR_W-1:0]          ier,
  input  logic [ISR_W-1:1]          w1c,
  output logic [ISR_W-1:0]          isr,
  output logic                      irq
);

  logic [ISR_W-1:1] r_prev;
  logic [ISR_W-1:1] r_sticky;
  logic             r_irq;
  logic [ISR_W-1:1] w_evt;
  logic [ISR_W-1:1] w_rise;
  logic             w_rxt;

  assign w_evt  = {rf_pari_err, rf_overrun, tf_empty};
  assign w_rise = w_evt & ~r_prev;
  // thr of zero makes this permanently true, which is intended
  assign w_rxt  = (rf_number >= thr);
  assign isr    = {r_sticky, w_rxt};
  assign irq    = r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_sticky <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= w_evt;
      // a new event outranks a simultaneous clear
      r_sticky <= (r_sticky & ~w1c) | w_rise;
      r_irq    <= |(isr & ier);
    end
  end

endmodule

// File: rtl/uart_ctrl_regs.sv
// Register front-end for one UART channel: access decode, FIFO push/pop
// handshakes, registered read data, and the interrupt controller.
module uart_ctrl_regs
  import uart_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         CNT_W     = 8,
  parameter int         DL_W      = 32,
  parameter int         DL_RESET  = 434,
  parameter logic [7:0] CTR_RESET = 8'h03
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              crl_sw,
  input  logic              crl_wr,
  input  logic [3:0]        crl_order,
  input  logic [31:0]       crl_wdata,
  output logic [31:0]       crl_rdata,
  output logic              crl_rvalid,
  output logic              crl_err,
  output logic              tf_push,
  output logic [DATA_W-1:0] tf_data,
  input  logic              tf_full,
  input  logic              tf_empty,
  input  logic              tf_overrun,
  input  logic [CNT_W-1:0]  tf_number,
  input  logic [4:0]        tf_state,
  output logic              rf_pop,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_empty,
  input  logic              rf_full,
  input  logic              rf_overrun,
  input  logic              rf_pari_err,
  input  logic [CNT_W-1:0]  rf_number,
  input  logic [4:0]        rf_state,
  output logic [7:0]        ctr,
  output logic [DL_W-1:0]   baud_div,
  output logic              rx_enable,
  output logic              irq
);

  logic [7:0]       r_ctr;
  logic [ISR_W-1:0] r_ier;
  logic [CNT_W-1:0] r_thr;
  logic [DL_W-1:0]  r_dl;
  logic             r_rxen;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic             r_err;

  logic             w_rd;
  logic             w_wr;
  logic             w_dlab;
  logic             w_ill;
  logic [31:0]      w_rsel;
  logic [ISR_W-1:0] w_isr;
  logic [ISR_W-1:1] w_w1c;

  assign w_rd   = crl_sw & ~crl_wr;
  assign w_wr   = crl_sw & crl_wr;
  assign w_dlab = r_ctr[CTR_DLAB_BIT];
  assign w_w1c  = (w_wr && crl_order == ORD_ISR) ? crl_wdata[ISR_W-1:1] : '0;

  // rst_n gating keeps an access caught by reset from moving a FIFO
  assign tf_push = rst_n & w_wr & (crl_order == ORD_TB) & ~tf_full;
  assign rf_pop  = rst_n & w_rd & (crl_order == ORD_RB) & ~rf_empty;
  assign tf_data = crl_wdata[DATA_W-1:0];

  assign crl_rdata  = r_rdata;
  assign crl_rvalid = r_rvalid;
  assign crl_err    = r_err;
  assign ctr        = r_ctr;
  assign baud_div   = r_dl;
  assign rx_enable  = r_rxen;

  // read mux plus legality of the current access (only meaningful with crl_sw)
  always_comb begin
    w_rsel = '0;
    w_ill  = 1'b0;
    case (crl_order)
      ORD_RB: begin
        w_rsel = rf_empty ? '0 : 32'(rf_data);
        w_ill  = crl_wr | rf_empty;
      end
      ORD_IER: w_rsel = 32'(r_ier);
      ORD_CTR: w_rsel = 32'(r_ctr);
      ORD_STR: begin
        w_rsel = 32'({irq, tf_overrun, tf_full, rf_full,
                      tf_empty, rf_pari_err, rf_overrun, ~rf_empty});
        w_ill  = crl_wr;
      end
      ORD_DL: begin
        w_rsel = 32'(r_dl);
        w_ill  = crl_wr & ~w_dlab;
      end
      ORD_DBG: begin
        w_rsel = 32'({rf_state, tf_state, rf_number, tf_number});
        w_ill  = crl_wr;
      end
      ORD_TB:  w_ill  = ~crl_wr | tf_full;
      ORD_THR: w_rsel = 32'(r_thr);
      ORD_ISR: w_rsel = 32'(w_isr);
      default: w_ill  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr    <= CTR_RESET;
      r_ier    <= IER_RESET;
      r_thr    <= CNT_W'(THR_RESET);
      r_dl     <= DL_W'(DL_RESET);
      r_rxen   <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= crl_sw & w_ill;
      if (w_rd) r_rdata <= w_rsel;
      if (w_wr) begin
        case (crl_order)
          ORD_IER: r_ier <= crl_wdata[ISR_W-1:0];
          ORD_CTR: begin
            r_ctr <= crl_wdata[7:0];
            if (w_dlab && !crl_wdata[CTR_DLAB_BIT]) r_rxen <= 1'b1;
          end
          ORD_DL:  if (w_dlab) r_dl <= crl_wdata[DL_W-1:0];
          ORD_THR: r_thr <= crl_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  uart_irq_ctrl #(.CNT_W(CNT_W)) u_irq (
    .clk        (clk),
    .rst_n      (rst_n),
    .tf_empty   (tf_empty),
    .rf_overrun (rf_overrun),
    .rf_pari_err(rf_pari_err),
    .rf_number  (rf_number),
    .thr        (r_thr),
    .ier        (r_ier),
    .w1c        (w_w1c),
    .isr        (w_isr),
    .irq        (irq)
  );

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// Bench for uart_ctrl_regs: directed scenarios then random traffic, all
// checked against a per-access behavioural model of the register file.
module tb_uart_ctrl_regs;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int DL_W   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              crl_sw = 0, crl_wr = 0;
  logic [3:0]        crl_order = 0;
  logic [31:0]       crl_wdata = 0;
  logic [31:0]       crl_rdata;
  logic              crl_rvalid, crl_err, tf_push, rf_pop, rx_enable, irq;
  logic [DATA_W-1:0] tf_data;
  logic              tf_full = 0, tf_empty = 1, tf_overrun = 0;
  logic [CNT_W-1:0]  tf_number = 0, rf_number = 0;
  logic [4:0]        tf_state = 0, rf_state = 0;
  logic [DATA_W-1:0] rf_data = 0;
  logic              rf_empty = 1, rf_full = 0, rf_overrun = 0, rf_pari_err = 0;
  logic [7:0]        ctr;
  logic [DL_W-1:0]   baud_div;

  uart_ctrl_regs #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DL_W(DL_W),
                   .DL_RESET(434), .CTR_RESET(8'h03)) dut (
    .clk(clk), .rst_n(rst_n), .crl_sw(crl_sw), .crl_wr(crl_wr),
    .crl_order(crl_order), .crl_wdata(crl_wdata), .crl_rdata(crl_rdata),
    .crl_rvalid(crl_rvalid), .crl_err(crl_err), .tf_push(tf_push),
    .tf_data(tf_data), .tf_full(tf_full), .tf_empty(tf_empty),
    .tf_overrun(tf_overrun), .tf_number(tf_number), .tf_state(tf_state),
    .rf_pop(rf_pop), .rf_data(rf_data), .rf_empty(rf_empty),
    .rf_full(rf_full), .rf_overrun(rf_overrun), .rf_pari_err(rf_pari_err),
    .rf_number(rf_number), .rf_state(rf_state), .ctr(ctr),
    .baud_div(baud_div), .rx_enable(rx_enable), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state, advanced once per clock
  logic [7:0] m_ctr;
  int         m_ier, m_thr, m_rdata;
  logic [31:0] m_dl;
  bit         m_rxen, m_irq, m_rv, m_err;
  bit [3:1]   m_st, m_prev;

  task automatic m_reset();
    m_ctr = 8'h03; m_ier = 0; m_thr = 1; m_dl = 434; m_rxen = 0; m_irq = 0;
    m_st = '0; m_prev = '0; m_rdata = 0; m_rv = 0; m_err = 0;
  endtask

  function automatic int isr_now();
    return int'(m_st) * 2 + ((int'(rf_number) >= m_thr) ? 1 : 0);
  endfunction

  function automatic bit legal(input bit wr, input int ord);
    case (ord)
      1:          return !wr && !rf_empty;
      2, 3, 8, 9: return 1'b1;
      4, 6:       return !wr;
      5:          return !wr || m_ctr[5];
      7:          return wr && !tf_full;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_read(input int ord);
    case (ord)
      1: return rf_empty ? 0 : int'(rf_data);
      2: return m_ier;
      3: return int'(m_ctr);
      4: return (int'(m_irq) << 7) | (int'(tf_overrun) << 6) | (int'(tf_full) << 5) |
                (int'(rf_full) << 4) | (int'(tf_empty) << 3) | (int'(rf_pari_err) << 2) |
                (int'(rf_overrun) << 1) | int'(!rf_empty);
      5: return int'(m_dl);
      6: return int'(tf_number) | (int'(rf_number) << 8) | (int'(tf_state) << 16) |
                (int'(rf_state) << 21);
      8: return m_thr;
      9: return isr_now();
      default: return 0;
    endcase
  endfunction

  // one bus cycle: drive at negedge, check comb outputs, predict, check after edge
  task automatic step(input bit sw, input bit wr, input logic [3:0] ord, input logic [31:0] wd);
    int  isr, o;
    bit  ok, n_irq;
    bit [3:1] rise;
    crl_sw = sw; crl_wr = wr; crl_order = ord; crl_wdata = wd;
    #1;
    o = int'(ord);
    chk("tf_push", tf_push, sw && wr && o == 7 && !tf_full);
    chk("rf_pop",  rf_pop,  sw && !wr && o == 1 && !rf_empty);
    chk("tf_data", tf_data, wd[7:0]);
    ok    = legal(wr, o);
    isr   = isr_now();
    n_irq = (isr & m_ier) != 0;
    m_rv  = sw && !wr;
    m_err = sw && !ok;
    if (m_rv) m_rdata = m_read(o);
    rise = {rf_pari_err, rf_overrun, tf_empty} & ~m_prev;
    for (int i = 1; i <= 3; i++) begin
      if (rise[i]) m_st[i] = 1'b1;
      else if (sw && wr && o == 9 && wd[i]) m_st[i] = 1'b0;
    end
    m_prev = {rf_pari_err, rf_overrun, tf_empty};
    if (sw && wr && ok) begin
      case (o)
        2: m_ier = int'(wd & 32'hF);
        3: begin
          if (m_ctr[5] && !wd[5]) m_rxen = 1'b1;
          m_ctr = wd[7:0];
        end
        5: m_dl = wd;
        8: m_thr = int'(wd[7:0]);
        default: ;
      endcase
    end
    m_irq = n_irq;
    @(posedge clk);
    #1;
    chk("rvalid",   crl_rvalid, m_rv);
    chk("err",      crl_err,    m_err);
    chk("rdata",    crl_rdata,  m_rdata);
    chk("ctr",      ctr,        m_ctr);
    chk("baud_div", baud_div,   m_dl);
    chk("rx_en",    rx_enable,  m_rxen);
    chk("irq",      irq,        m_irq);
    @(negedge clk);
  endtask

  initial begin
    // access in flight while reset is held must not move either FIFO
    crl_sw = 1; crl_wr = 1; crl_order = 4'd7; crl_wdata = 32'h5A; tf_full = 0;
    #2 chk("rst_push", tf_push, 1'b0);
    crl_wr = 0; crl_order = 4'd1; rf_empty = 0;
    #1 chk("rst_pop", rf_pop, 1'b0);
    crl_sw = 0; rf_empty = 1;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    m_reset();
    #1;
    chk("rst_rdata", crl_rdata, 0);
    chk("rst_rvalid", crl_rvalid, 0);
    chk("rst_err", crl_err, 0);
    chk("rst_ctr", ctr, 8'h03);
    chk("rst_baud", baud_div, 434);
    chk("rst_rxen", rx_enable, 0);
    chk("rst_irq", irq, 0);
    #3;

    // reset readback
    step(1, 0, 4'd3, 0); chk("t1_ctr", crl_rdata, 32'h03);
    step(1, 0, 4'd5, 0); chk("t1_dl",  crl_rdata, 434);
    step(1, 0, 4'd9, 0); chk("t1_isr", crl_rdata, 32'h2);

    // divisor latch gated by DLAB, rx_enable on DLAB fall
    step(1, 1, 4'd5, 32'h1B2); chk("t2_dl_err", crl_err, 1); chk("t2_baud_hold", baud_div, 434);
    step(1, 1, 4'd3, 32'h23);
    step(1, 1, 4'd5, 32'h1B2); chk("t2_baud", baud_div, 32'h1B2);
    step(1, 1, 4'd3, 32'h03); chk("t2_rxen", rx_enable, 1);

    // rx FIFO reads back to back, then from empty
    rf_empty = 0; rf_data = 8'h41;
    step(1, 0, 4'd1, 0); chk("t3_rb0", crl_rdata, 32'h41);
    rf_data = 8'h42;
    step(1, 0, 4'd1, 0); chk("t3_rb1", crl_rdata, 32'h42);
    rf_empty = 1;
    step(1, 0, 4'd1, 0); chk("t3_rb_empty", crl_rdata, 0); chk("t3_err", crl_err, 1);

    // tx push blocked by full
    tf_full = 1; step(1, 1, 4'd7, 32'h55); chk("t4_err", crl_err, 1);
    tf_full = 0; step(1, 1, 4'd7, 32'h55);

    // sticky overrun, set beats W1C
    step(1, 1, 4'd2, 32'h4);
    rf_overrun = 1; step(0, 0, 0, 0);
    step(0, 0, 0, 0); chk("t5_irq_on", irq, 1);
    rf_overrun = 0; step(0, 0, 0, 0);
    rf_overrun = 1; step(1, 1, 4'd9, 32'h4);
    step(1, 0, 4'd9, 0); chk("t5_rov_kept", (crl_rdata >> 2) & 1, 1);
    rf_overrun = 0; step(1, 1, 4'd9, 32'h4);
    step(0, 0, 0, 0); chk("t5_irq_off", irq, 0);

    // rx threshold level interrupt
    step(1, 1, 4'd8, 32'd3);
    step(1, 1, 4'd2, 32'h1);
    rf_number = 2; step(0, 0, 0, 0); chk("t6_irq_a", irq, 0);
    rf_number = 3; step(0, 0, 0, 0); chk("t6_irq_b", irq, 1);
    rf_number = 2; step(0, 0, 0, 0); chk("t6_irq_c", irq, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  ord;
      logic [31:0] wd;
      tf_full     = ($urandom_range(0, 3) == 0);
      tf_empty    = ($urandom_range(0, 2) == 0);
      tf_overrun  = $urandom_range(0, 1);
      rf_empty    = ($urandom_range(0, 3) == 0);
      rf_full     = $urandom_range(0, 1);
      rf_overrun  = ($urandom_range(0, 3) == 0);
      rf_pari_err = ($urandom_range(0, 3) == 0);
      rf_number   = CNT_W'($urandom_range(0, 7));
      tf_number   = CNT_W'($urandom);
      tf_state    = 5'($urandom);
      rf_state    = 5'($urandom);
      rf_data     = DATA_W'($urandom);
      ord = 4'($urandom_range(0, 11));
      wd  = $urandom;
      if (ord == 4'd8) wd = wd & 32'h7;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), ord, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
